// File: rtl/des_key_schedule_if.sv
// Handshake bundle for the DES key schedule: key load side and subkey stream side.
// Bit 0 of key/subkey is the leftmost (FIPS bit 1) bit, hence the ascending ranges.
interface des_key_schedule_if;
    logic [0:63] key;
    logic        decrypt;
    logic        load;
    logic        key_ready;
    logic        clear;
    logic [0:47] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round;
    logic        done;
    logic        key_parity_err;

    modport master (
        output key, decrypt, load, clear, subkey_ready,
        input  key_ready, subkey, subkey_valid, round, done, key_parity_err
    );

    modport slave (
        input  key, decrypt, load, clear, subkey_ready,
        output key_ready, subkey, subkey_valid, round, done, key_parity_err
    );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: streams K1..K16 (encrypt) or K16..K1 (decrypt).
// Optional key byte parity check enabled by defining DES_KS_PARITY_CHECK_EN.
module des_key_schedule (
    input  logic              clk,
    input  logic              reset_n,
    des_key_schedule_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    // Zero-based permutation tables (FIPS entry minus one).
    localparam logic [5:0] PC1 [56] = '{
        6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,
        6'd0,  6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17,
        6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26,
        6'd18, 6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35,
        6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14,
        6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21,
        6'd13, 6'd5,  6'd60, 6'd52, 6'd44, 6'd36, 6'd28,
        6'd20, 6'd12, 6'd4,  6'd27, 6'd19, 6'd11, 6'd3
    };
    localparam logic [5:0] PC2 [48] = '{
        6'd13, 6'd16, 6'd10, 6'd23, 6'd0,  6'd4,
        6'd2,  6'd27, 6'd14, 6'd5,  6'd20, 6'd9,
        6'd22, 6'd18, 6'd11, 6'd3,  6'd25, 6'd7,
        6'd15, 6'd6,  6'd26, 6'd19, 6'd12, 6'd1,
        6'd40, 6'd51, 6'd30, 6'd36, 6'd46, 6'd54,
        6'd29, 6'd39, 6'd50, 6'd44, 6'd32, 6'd47,
        6'd43, 6'd48, 6'd38, 6'd55, 6'd33, 6'd52,
        6'd45, 6'd41, 6'd49, 6'd35, 6'd28, 6'd31
    };

    function automatic logic [0:27] rotl(input logic [0:27] h, input logic two);
        return two ? {h[2:27], h[0:1]} : {h[1:27], h[0]};
    endfunction

    function automatic logic [0:27] rotr(input logic [0:27] h, input logic two);
        return two ? {h[26:27], h[0:25]} : {h[27], h[0:26]};
    endfunction

    state_t      state, state_n;
    logic [0:55] cd, cd_n, pc1_key;
    logic [3:0]  round, round_n;
    logic        dec, dec_n, done, done_n;
    logic [4:0]  sidx;
    logic        two;

    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign pc1_key[i] = bus.key[PC1[i]];
    end

    for (genvar i = 0; i < 48; i++) begin : g_pc2
        assign bus.subkey[i] = cd[PC2[i]];
    end

    // Schedule entry for the next subkey: K(round+2) going forward, undoing K(16-round) going back.
    assign sidx = dec ? (5'd16 - {1'b0, round}) : ({1'b0, round} + 5'd2);
    assign two  = !(sidx == 5'd1 || sidx == 5'd2 || sidx == 5'd9 || sidx == 5'd16);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cd    <= '0;
            round <= '0;
            dec   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cd    <= cd_n;
            round <= round_n;
            dec   <= dec_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cd_n    = cd;
        round_n = round;
        dec_n   = dec;
        done_n  = 1'b0;
        if (bus.clear) begin
            state_n = IDLE;
            round_n = '0;
        end else begin
            case (state)
                IDLE: if (bus.load) begin
                    dec_n   = bus.decrypt;
                    // Decrypt starts from C16/D16, which equal C0/D0 after a full 28-bit rotation.
                    cd_n    = bus.decrypt ? pc1_key
                                          : {rotl(pc1_key[0:27], 1'b0), rotl(pc1_key[28:55], 1'b0)};
                    state_n = RUN;
                    round_n = '0;
                end
                RUN: if (bus.subkey_ready) begin
                    if (round == 4'd15) begin
                        state_n = IDLE;
                        round_n = '0;
                        done_n  = 1'b1;
                    end else begin
                        round_n = round + 4'd1;
                        cd_n    = dec ? {rotr(cd[0:27], two), rotr(cd[28:55], two)}
                                      : {rotl(cd[0:27], two), rotl(cd[28:55], two)};
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.key_ready    = (state == IDLE);
    assign bus.subkey_valid = (state == RUN);
    assign bus.round        = round;
    assign bus.done         = done;

`ifdef DES_KS_PARITY_CHECK_EN
    logic [7:0] byte_even;
    logic       par_err;

    for (genvar j = 0; j < 8; j++) begin : g_par
        assign byte_even[j] = ~^bus.key[8*j +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          par_err <= 1'b0;
        else if (bus.clear)                    par_err <= 1'b0;
        else if (state == IDLE && bus.load)    par_err <= |byte_even;
    end

    assign bus.key_parity_err = par_err;
`else
    // Parity bits are dropped by PC-1; gathered here only so they are not flagged as dangling.
    logic [7:0] unused_par_bits;
    for (genvar j = 0; j < 8; j++) begin : g_par
        assign unused_par_bits[j] = bus.key[8*j + 7];
    end

    assign bus.key_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: table of full-stream vectors plus corner sequences.
module tb_des_key_schedule;
    logic clk;
    logic reset_n;
    des_key_schedule_if bus();

    des_key_schedule dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef DES_KS_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h123457799BBCDFF1;

    // K1..K16 for KEY_A.
    logic [47:0] ks [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    typedef struct {
        logic [63:0] key;
        logic        dec;
        logic        check_keys;
        logic        perr;
    } vec_t;

    vec_t vecs [4];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
    task automatic start(input logic [63:0] k, input logic d);
        chk("key_ready_before_load", 64'(bus.key_ready), 64'd1);
        bus.key     = k;
        bus.decrypt = d;
        bus.load    = 1'b1;
        @(negedge clk);
        bus.load    = 1'b0;
        bus.decrypt = ~d;
    endtask

    task automatic check_step(input int r, input logic d, input logic ck);
        chk($sformatf("valid_r%0d", r), 64'(bus.subkey_valid), 64'd1);
        chk($sformatf("round_r%0d", r), 64'(bus.round), 64'(r));
        if (ck)
            chk($sformatf("subkey_%s_r%0d", d ? "dec" : "enc", r), 64'(bus.subkey),
                64'(d ? ks[15-r] : ks[r]));
    endtask

    // Full stream with subkey_ready high; ends at the negedge of the done cycle.
    task automatic run_stream(input vec_t v);
        bus.subkey_ready = 1'b1;
        start(v.key, v.dec);
        chk("parity_err", 64'(bus.key_parity_err), 64'(PAR_EN & v.perr));
        for (int r = 0; r < 16; r++) begin
            check_step(r, v.dec, v.check_keys);
            @(negedge clk);
        end
        chk("done_pulse", 64'(bus.done), 64'd1);
        chk("key_ready_at_done", 64'(bus.key_ready), 64'd1);
        chk("valid_at_done", 64'(bus.subkey_valid), 64'd0);
        chk("round_at_done", 64'(bus.round), 64'd0);
    endtask

    initial begin
        vecs[0] = '{key: KEY_A, dec: 1'b0, check_keys: 1'b1, perr: 1'b0};
        vecs[1] = '{key: KEY_A, dec: 1'b1, check_keys: 1'b1, perr: 1'b0};
        vecs[2] = '{key: KEY_B, dec: 1'b0, check_keys: 1'b0, perr: 1'b1};
        vecs[3] = '{key: KEY_A, dec: 1'b1, check_keys: 1'b1, perr: 1'b0};

        reset_n          = 1'b0;
        bus.key          = '0;
        bus.decrypt      = 1'b0;
        bus.load         = 1'b0;
        bus.clear        = 1'b0;
        bus.subkey_ready = 1'b0;
        #12;
        chk("rst_key_ready", 64'(bus.key_ready), 64'd1);
        chk("rst_valid", 64'(bus.subkey_valid), 64'd0);
        chk("rst_round", 64'(bus.round), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_perr", 64'(bus.key_parity_err), 64'd0);
        chk("rst_subkey", 64'(bus.subkey), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Back-to-back streams: each load lands in the previous done cycle.
        for (int v = 0; v < 4; v++) run_stream(vecs[v]);
        @(negedge clk);
        chk("done_falls", 64'(bus.done), 64'd0);
        chk("idle_after_stream", 64'(bus.subkey_valid), 64'd0);

        // Backpressure at round 3 for 5 cycles.
        bus.subkey_ready = 1'b1;
        start(KEY_A, 1'b0);
        for (int r = 0; r < 3; r++) begin
            check_step(r, 1'b0, 1'b1);
            @(negedge clk);
        end
        bus.subkey_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_step(3, 1'b0, 1'b1);
        end
        bus.subkey_ready = 1'b1;
        for (int r = 3; r < 16; r++) begin
            check_step(r, 1'b0, 1'b1);
            @(negedge clk);
        end
        chk("bp_done", 64'(bus.done), 64'd1);
        @(negedge clk);

        // clear at round 7 beats a simultaneous load and transfer.
        start(KEY_A, 1'b0);
        for (int r = 0; r < 7; r++) @(negedge clk);
        check_step(7, 1'b0, 1'b1);
        bus.clear = 1'b1;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        bus.load  = 1'b0;
        chk("clr_key_ready", 64'(bus.key_ready), 64'd1);
        chk("clr_valid", 64'(bus.subkey_valid), 64'd0);
        chk("clr_round", 64'(bus.round), 64'd0);
        chk("clr_no_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        chk("clr_no_done2", 64'(bus.done), 64'd0);
        chk("clr_load_ignored", 64'(bus.subkey_valid), 64'd0);
        run_stream(vecs[0]);
        @(negedge clk);

        // Asynchronous reset at round 10.
        start(KEY_A, 1'b1);
        for (int r = 0; r < 10; r++) @(negedge clk);
        check_step(10, 1'b1, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_key_ready", 64'(bus.key_ready), 64'd1);
        chk("arst_valid", 64'(bus.subkey_valid), 64'd0);
        chk("arst_round", 64'(bus.round), 64'd0);
        chk("arst_subkey", 64'(bus.subkey), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_stream(vecs[1]);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Sequential DES key-schedule generator. Accepts a 64-bit key, applies PC-1, then streams the 16 round subkeys K1..K16 (encrypt) or K16..K1 (decrypt) over a valid/ready handshake, one per accepted transfer. Sits between the key register and the round datapath, so one round engine serves both directions.

## Interface
- Parameters: none.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- key  input  64  key with parity bits; index i = FIPS 46-3 bit i+1 (index 0 = leftmost/MSB of hex vector).
- decrypt  input  1  sampled with load: 0 = K1..K16, 1 = K16..K1.
- load  input  1  key load request; accepted only when key_ready=1.
- key_ready  output  1  high in IDLE.
- clear  input  1  synchronous abort to IDLE.
- subkey  output  48  current round subkey; index i = FIPS bit i+1.
- subkey_valid  output  1  subkey is presented.
- subkey_ready  input  1  consumer accepts subkey on valid&ready.
- round  output  4  0..15 = position in stream (0 = first subkey delivered).
- done  output  1  one-cycle pulse after the 16th transfer.
- key_parity_err  output  1  see Configuration.

## Operation
- States: IDLE, RUN. Reset: IDLE, key_ready=1, subkey_valid=0, round=0, done=0, key_parity_err=0, CD register=0.
- 56-bit CD register: C = CD[27:0], D = CD[55:28]. subkey = PC-2(CD), combinational from CD only (never from inputs).
- Rotate-left by n per half: new[i] = old[(i+n) mod 28]; rotate-right: new[i] = old[(i-n) mod 28].
- Shift schedule s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- IDLE & load: latch direction; encrypt: CD <= rotl(PC-1(key), 1); decrypt: CD <= PC-1(key) (C16=C0). Go RUN, round=0.
- RUN, transfer (valid&ready) with round<15: round+1; encrypt: CD <= rotl(CD, s[round+2]); decrypt: CD <= rotr(CD, s[16-round]).
- RUN, transfer with round=15: go IDLE, done=1 next cycle, round=0, CD retained.
- RUN, no transfer: all state held; subkey stable (backpressure).
- load while RUN: ignored. decrypt changes outside load: ignored.
- clear: IDLE next edge from any state, round=0, no done pulse; clear has priority over load and transfer in the same cycle.
- reset_n low mid-stream: immediate return to reset state.

## Timing
- Load accepted at edge N: subkey_valid=1 with first subkey after edge N; latency 1 cycle.
- With subkey_ready held high: 16 consecutive transfers, done pulse in cycle after the 16th, key_ready=1 same cycle as done.
- load in the same cycle as done (IDLE) is accepted: back-to-back keys with no bubble beyond the done cycle.
- key_ready, subkey_valid, round, done are registered outputs.

## Configuration
- DES_KS_PARITY_CHECK_EN defined: on accepted load, key_parity_err <= 1 if any byte key[8j+7:8j] (j=0..7) has even parity, else 0; held until next accepted load, clear, or reset. Stream proceeds regardless.
- Undefined: key_parity_err tied 0; no parity logic.

## Test plan
- Encrypt, key 133457799BBCDFF1, ready high -> round0 subkey 1B02EFFC7072, round1 79AED9DBC9E5, round15 CB3D8B0E17F5, done 1 cycle after 16th transfer.
- Decrypt, same key -> round0 CB3D8B0E17F5, round14 79AED9DBC9E5, round15 1B02EFFC7072; full sequence is exact reverse of encrypt.
- Backpressure: drop subkey_ready for 5 cycles at round 3 -> subkey, round, valid unchanged; resumes with round 4, 16 transfers total.
- clear asserted at round 7 with load also high -> IDLE, no done, load ignored; new load afterwards restarts at round 0.
- reset_n pulsed low at round 10 -> outputs to reset values asynchronously; load after release streams from round 0.
- With DES_KS_PARITY_CHECK_EN: key 133457799BBCDFF1 -> key_parity_err=0; key 123457799BBCDFF1 -> key_parity_err=1, stream still produced.
